// File: rtl/popcount_stream_acc.sv
// Streaming popcount accumulator: sums popcount(in_data) over BEATS words, emits total + fire.
// Define POPCOUNT_STREAM_APPROX_EN to drop bit 0 of each per-beat count.
module popcount_stream_acc #(
    parameter int WIDTH = 4,
    parameter int BEATS = 8,
    localparam int CNT_W = $clog2(WIDTH * BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] threshold,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_fire
);

    localparam int PC_W   = $clog2(WIDTH + 1);
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t state;
    state_t state_n;

    logic              live;
    logic [CNT_W-1:0]  acc;
    logic [BEAT_W-1:0] beat;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_use;
    logic [CNT_W-1:0]  sum;
    logic              accept;
    logic              last;

    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + PC_W'(in_data[i]);
        end
    end

`ifdef POPCOUNT_STREAM_APPROX_EN
    // Bit 0 tied low so the LSB adder column folds away.
    assign pc_use = pc & ~PC_W'(1);
`else
    assign pc_use = pc;
`endif

    assign sum    = acc + CNT_W'(pc_use);
    assign last   = (beat == BEAT_W'(BEATS - 1));
    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = live;
                if (!flush && accept && last) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    state_n = ACCUM;
                end
            end
            default: state_n = ACCUM;
        endcase
    end

    // live keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live      <= 1'b0;
            acc       <= '0;
            beat      <= '0;
            out_count <= '0;
            out_fire  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (flush) begin
                acc  <= '0;
                beat <= '0;
            end else if (accept) begin
                if (last) begin
                    out_count <= sum;
                    out_fire  <= (sum >= threshold);
                    acc       <= '0;
                    beat      <= '0;
                end else begin
                    acc  <= sum;
                    beat <= beat + BEAT_W'(1);
                end
            end
        end
    end

endmodule
